// File: rtl/arrow_pkg.sv
// Types and constants shared by the arrow motion block and the arrow drawing stage.
package arrow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SPAWN  = 2'd2
  } state_e;

  // Off-screen parking row for inactive lanes; must leave headroom for the arrow size.
  localparam int PARK_Y = 1000;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length LFSR that picks the spawn lane; it advances only when enabled.
module lfsr8
  import arrow_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [7:0] seed,
  output logic [7:0] q_o
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  assign q_d = en_i ? lfsr8_next(q_q) : q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/arrow_motion.sv
// Rhythm-game arrow lanes: per-frame scroll toward the hit zone, periodic spawning,
// button hit detection with a saturating score, and miss reporting.
module arrow_motion
  import arrow_pkg::*;
#(
  parameter int         CORDW        = 10,
  parameter int         ARROW_COUNT  = 3,
  parameter int         ARROW_SIZE   = 5,
  parameter int         SCREEN_H     = 480,
  parameter int         SPEED        = 2,
  parameter int         TARGET_Y     = 40,
  parameter int         HIT_WIN      = 8,
  parameter int         SPAWN_PERIOD = 30,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         frame_i,
  input  logic                         run_i,
  input  logic [ARROW_COUNT-1:0]       btn_i,
  output logic [CORDW*ARROW_COUNT-1:0] arrow_y_o,
  output logic [ARROW_COUNT-1:0]       arrow_vld_o,
  output logic                         hit_o,
  output logic                         miss_o,
  output logic [15:0]                  score_o
);

  localparam int LW = (ARROW_COUNT > 1) ? $clog2(ARROW_COUNT) : 1;
  localparam int FW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  localparam logic [CORDW-1:0] PARK       = CORDW'(PARK_Y);
  localparam logic [CORDW-1:0] SPAWN_Y    = CORDW'(SCREEN_H - ARROW_SIZE - 1);
  localparam logic [CORDW-1:0] STEP       = CORDW'(SPEED);
  localparam logic [CORDW-1:0] MISS_LIM   = CORDW'(SPEED + SPEED);
  localparam logic [CORDW-1:0] WIN_LO     = CORDW'(TARGET_Y - HIT_WIN);
  localparam logic [CORDW-1:0] WIN_HI     = CORDW'(TARGET_Y + HIT_WIN);
  localparam logic [LW-1:0]    LAST_LANE  = LW'(ARROW_COUNT - 1);
  localparam logic [FW-1:0]    LAST_FRAME = FW'(SPAWN_PERIOD - 1);

  state_e                       state_q;
  logic [LW-1:0]                lane_q;
  logic [FW-1:0]                fcnt_q;
  logic [CORDW*ARROW_COUNT-1:0] y_q, y_d;
  logic [ARROW_COUNT-1:0]       vld_q, vld_d;
  logic [ARROW_COUNT-1:0]       pend_q, pend_d;
  logic [15:0]                  score_q, score_d;
  logic                         hit_q, miss_q;

  logic [ARROW_COUNT-1:0] hit_lane, miss_lane, spawn_lane, move_lane;
  logic [16:0]            score_sum;
  logic                   evaluate, attempt;
  logic [7:0]             lfsr_q;
  logic                   lfsr_unused;

  assign evaluate = (state_q == ST_IDLE);
  assign attempt  = (state_q == ST_SPAWN) && (fcnt_q == LAST_FRAME);

  lfsr8 u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (attempt),
    .seed   (LFSR_SEED),
    .q_o    (lfsr_q)
  );

  // Only the two low LFSR bits choose a lane; the rest just carry the sequence.
  assign lfsr_unused = ^lfsr_q[7:2];

  for (genvar gi = 0; gi < ARROW_COUNT; gi++) begin : g_lane
    logic [CORDW-1:0] y;
    logic             sel;

    assign y   = y_q[gi*CORDW +: CORDW];
    assign sel = (state_q == ST_UPDATE) && (lane_q == LW'(gi));

    assign hit_lane[gi]   = evaluate && pend_q[gi] && vld_q[gi] && (y >= WIN_LO) && (y <= WIN_HI);
    assign miss_lane[gi]  = sel && vld_q[gi] && (y < MISS_LIM);
    assign move_lane[gi]  = sel && vld_q[gi];
    assign spawn_lane[gi] = attempt && !vld_q[gi] && (int'(lfsr_q[1:0]) == gi);
  end

  // Hits and misses retire a lane; otherwise a spawn or a scroll step may apply.
  always_comb begin
    y_d   = y_q;
    vld_d = vld_q;
    for (int i = 0; i < ARROW_COUNT; i++) begin
      if (hit_lane[i] || miss_lane[i]) begin
        vld_d[i]                 = 1'b0;
        y_d[i*CORDW +: CORDW]    = PARK;
      end else if (spawn_lane[i]) begin
        vld_d[i]                 = 1'b1;
        y_d[i*CORDW +: CORDW]    = SPAWN_Y;
      end else if (move_lane[i]) begin
        y_d[i*CORDW +: CORDW]    = y_q[i*CORDW +: CORDW] - STEP;
      end
    end
  end

  always_comb begin
    score_sum = {1'b0, score_q};
    for (int i = 0; i < ARROW_COUNT; i++) begin
      score_sum = score_sum + {16'd0, hit_lane[i]};
    end
    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Presses that land on the evaluation cycle survive into the next evaluation.
  assign pend_d = (evaluate ? '0 : pend_q) | btn_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      fcnt_q  <= '0;
      y_q     <= {ARROW_COUNT{PARK}};
      vld_q   <= '0;
      pend_q  <= '0;
      score_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      vld_q   <= vld_d;
      pend_q  <= pend_d;
      score_q <= score_d;
      hit_q   <= |hit_lane;
      miss_q  <= |miss_lane;
      case (state_q)
        ST_IDLE: begin
          if (frame_i && run_i) begin
            state_q <= ST_UPDATE;
            lane_q  <= '0;
          end
        end
        ST_UPDATE: begin
          if (lane_q == LAST_LANE) begin
            state_q <= ST_SPAWN;
          end else begin
            lane_q <= lane_q + 1'b1;
          end
        end
        ST_SPAWN: begin
          state_q <= ST_IDLE;
          fcnt_q  <= (fcnt_q == LAST_FRAME) ? '0 : fcnt_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign arrow_y_o   = y_q;
  assign arrow_vld_o = vld_q;
  assign hit_o       = hit_q;
  assign miss_o      = miss_q;
  assign score_o     = score_q;

endmodule

// File: tb/tb_arrow_motion.sv
// Bench for arrow_motion: frame-level reference model of lanes, score, spawn counter and LFSR.
module tb_arrow_motion;

  localparam int N       = 3;
  localparam int CW      = 10;
  localparam int SPEED   = 2;
  localparam int SP      = 30;
  localparam int SPAWN_Y = 474;
  localparam int PARK    = 1000;
  localparam int WLO     = 32;
  localparam int WHI     = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame = 1'b0;
  logic          run = 1'b0;
  logic [N-1:0]  btn = '0;
  logic [CW*N-1:0] arrow_y;
  logic [N-1:0]  arrow_vld;
  logic          hit, miss;
  logic [15:0]   score;

  arrow_motion dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .frame_i     (frame),
    .run_i       (run),
    .btn_i       (btn),
    .arrow_y_o   (arrow_y),
    .arrow_vld_o (arrow_vld),
    .hit_o       (hit),
    .miss_o      (miss),
    .score_o     (score)
  );

  always #5 clk = ~clk;

  int hit_seen = 0;
  int miss_seen = 0;
  always @(negedge clk) begin
    if (hit === 1'b1) hit_seen++;
    if (miss === 1'b1) miss_seen++;
  end

  int         m_y [N];
  bit         m_vld [N];
  int         m_score, m_fcnt, exp_hits, exp_misses;
  logic [7:0] m_lfsr;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [7:0] poly_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin m_y[i] = PARK; m_vld[i] = 0; end
    m_score = 0; m_fcnt = 0; m_lfsr = 8'hA5;
  endfunction

  function automatic void model_frame();
    int lane;
    for (int i = 0; i < N; i++) begin
      if (m_vld[i]) begin
        if (m_y[i] < 2 * SPEED) begin m_vld[i] = 0; m_y[i] = PARK; exp_misses++; end
        else m_y[i] -= SPEED;
      end
    end
    if (m_fcnt == SP - 1) begin
      m_fcnt = 0;
      lane = m_lfsr % 4;
      if (lane < N && !m_vld[lane]) begin m_vld[lane] = 1; m_y[lane] = SPAWN_Y; end
      m_lfsr = poly_step(m_lfsr);
    end else begin
      m_fcnt++;
    end
  endfunction

  function automatic void model_press(input logic [N-1:0] m);
    int n = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i] && m_vld[i] && m_y[i] >= WLO && m_y[i] <= WHI) begin
        m_vld[i] = 0; m_y[i] = PARK; n++;
      end
    end
    if (n > 0) begin
      m_score = (m_score + n > 65535) ? 65535 : m_score + n;
      exp_hits++;
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic frame_pulse(input bit r);
    run = r; frame = 1'b1;
    @(posedge clk); #1 frame = 1'b0;
    repeat (N + 2) @(posedge clk);
    #1;
    if (r) model_frame();
  endtask

  task automatic press(input logic [N-1:0] m);
    btn = m;
    @(posedge clk); #1 btn = '0;
    repeat (2) @(posedge clk);
    #1 model_press(m);
  endtask

  // Loads the model's lane/score state into the DUT registers while it idles.
  task automatic force_model();
    logic [CW*N-1:0] yv;
    logic [N-1:0]    vv;
    for (int i = 0; i < N; i++) begin yv[i*CW +: CW] = CW'(m_y[i]); vv[i] = m_vld[i]; end
    force dut.y_q = yv;
    force dut.vld_q = vv;
    force dut.score_q = 16'(m_score);
    @(posedge clk); #1;
    release dut.y_q;
    release dut.vld_q;
    release dut.score_q;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (arrow_y !== {N{10'd1000}} || arrow_vld !== '0 || score !== 16'd0 || hit !== 1'b0 || miss !== 1'b0) begin
      errors++;
      $display("FAIL reset y=%h vld=%b score=%0d hit=%b miss=%b want all lanes 1000, vld 0, score 0, no pulses",
               arrow_y, arrow_vld, score, hit, miss);
    end
  endtask

  task automatic test_spawn();
    for (int f = 1; f <= SP; f++) begin
      frame_pulse(1'b1);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (arrow_y[i*CW +: CW] !== CW'(m_y[i]) || arrow_vld[i] !== m_vld[i]) begin
          errors++;
          $display("FAIL spawn frame%0d lane%0d got y=%0d vld=%b want y=%0d vld=%b",
                   f, i, arrow_y[i*CW +: CW], arrow_vld[i], m_y[i], m_vld[i]);
        end
      end
    end
    checks++;
    if (arrow_vld !== 3'b010 || arrow_y[CW +: CW] !== 10'd474) begin
      errors++;
      $display("FAIL spawn30 got vld=%b y1=%0d want vld=010 y1=474", arrow_vld, arrow_y[CW +: CW]);
    end
  endtask

  task automatic test_descend_hit();
    repeat (217) frame_pulse(1'b1);
    checks++;
    if (arrow_y[CW +: CW] !== 10'd40 || arrow_vld[1] !== 1'b1) begin
      errors++;
      $display("FAIL descend got y1=%0d vld1=%b want y1=40 vld1=1", arrow_y[CW +: CW], arrow_vld[1]);
    end
    press(3'b010);
    checks++;
    if (arrow_y[CW +: CW] !== 10'd1000 || arrow_vld[1] !== 1'b0 || score !== 16'd1 || hit_seen != 1) begin
      errors++;
      $display("FAIL first_hit got y1=%0d vld1=%b score=%0d hits=%0d want 1000 0 1 1",
               arrow_y[CW +: CW], arrow_vld[1], score, hit_seen);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (arrow_y[i*CW +: CW] !== CW'(m_y[i]) || arrow_vld[i] !== m_vld[i]) begin
        errors++;
        $display("FAIL descend_state lane%0d got y=%0d vld=%b want y=%0d vld=%b",
                 i, arrow_y[i*CW +: CW], arrow_vld[i], m_y[i], m_vld[i]);
      end
    end
  endtask

  task automatic test_window();
    int ys [4] = '{49, 48, 32, 31};
    bit hits [4] = '{0, 1, 1, 0};
    int s0;
    for (int k = 0; k < 4; k++) begin
      m_y[1] = ys[k]; m_vld[1] = 1;
      force_model();
      s0 = m_score;
      press(3'b010);
      checks++;
      if (arrow_vld[1] !== !hits[k] || score !== 16'(s0 + int'(hits[k])) || score !== 16'(m_score)) begin
        errors++;
        $display("FAIL window y=%0d got vld1=%b score=%0d want vld1=%b score=%0d",
                 ys[k], arrow_vld[1], score, !hits[k], s0 + int'(hits[k]));
      end
      checks++;
      if (hit_seen != exp_hits) begin
        errors++;
        $display("FAIL window_pulse y=%0d got hits=%0d want %0d", ys[k], hit_seen, exp_hits);
      end
    end
  endtask

  task automatic test_miss();
    int m0;
    m_y[0] = 3; m_vld[0] = 1;
    force_model();
    m0 = miss_seen;
    frame_pulse(1'b1);
    checks++;
    if (miss_seen - m0 != 1 || arrow_vld[0] !== 1'b0 || arrow_y[0 +: CW] !== 10'd1000) begin
      errors++;
      $display("FAIL miss_y3 got misses=%0d vld0=%b y0=%0d want 1 0 1000", miss_seen - m0, arrow_vld[0], arrow_y[0 +: CW]);
    end
    m_y[0] = 4; m_vld[0] = 1;
    force_model();
    m0 = miss_seen;
    frame_pulse(1'b1);
    checks++;
    if (miss_seen != m0 || arrow_y[0 +: CW] !== 10'd2 || arrow_vld[0] !== 1'b1) begin
      errors++;
      $display("FAIL miss_y4 got misses=%0d y0=%0d vld0=%b want 0 2 1", miss_seen - m0, arrow_y[0 +: CW], arrow_vld[0]);
    end
    frame_pulse(1'b1);
    checks++;
    if (miss_seen - m0 != 1 || arrow_vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL miss_next got misses=%0d vld0=%b want 1 0", miss_seen - m0, arrow_vld[0]);
    end
    for (int i = 0; i < N; i++) begin m_y[i] = 2; m_vld[i] = 1; end
    force_model();
    m0 = miss_seen;
    frame_pulse(1'b1);
    checks++;
    if (miss_seen - m0 != 3 || miss_seen != exp_misses || arrow_vld !== '0) begin
      errors++;
      $display("FAIL miss_multi got misses=%0d total=%0d vld=%b want 3 %0d 000",
               miss_seen - m0, miss_seen, arrow_vld, exp_misses);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) begin m_y[i] = PARK; m_vld[i] = 0; end
    m_y[0] = 40; m_vld[0] = 1;
    force_model();
    run = 1'b1; frame = 1'b1;
    @(posedge clk); #1 btn = 3'b001;
    @(posedge clk); #1 frame = 1'b0; btn = '0;
    repeat (3) @(posedge clk);
    #1 model_frame();
    checks++;
    if (hit !== 1'b0 || arrow_vld[0] !== 1'b1 || arrow_y[0 +: CW] !== 10'd38) begin
      errors++;
      $display("FAIL pend_early got hit=%b vld0=%b y0=%0d want 0 1 38", hit, arrow_vld[0], arrow_y[0 +: CW]);
    end
    @(posedge clk); #1 model_press(3'b001);
    checks++;
    if (hit !== 1'b1 || arrow_vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL pend_hit got hit=%b vld0=%b want 1 0", hit, arrow_vld[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (hit !== 1'b0 || hit_seen != exp_hits || score !== 16'(m_score)) begin
      errors++;
      $display("FAIL pend_pulse got hit=%b hits=%0d score=%0d want 0 %0d %0d", hit, hit_seen, score, exp_hits, m_score);
    end
  endtask

  task automatic test_saturate();
    int h0;
    m_score = 100; m_y[0] = 40; m_vld[0] = 1; m_y[1] = PARK; m_vld[1] = 0; m_y[2] = 44; m_vld[2] = 1;
    force_model();
    h0 = hit_seen;
    press(3'b101);
    checks++;
    if (score !== 16'd102 || hit_seen - h0 != 1 || arrow_vld !== 3'b000) begin
      errors++;
      $display("FAIL double_hit got score=%0d pulses=%0d vld=%b want 102 1 000", score, hit_seen - h0, arrow_vld);
    end
    m_score = 65534;
    for (int i = 0; i < N; i++) begin m_y[i] = 36 + 4 * i; m_vld[i] = 1; end
    force_model();
    press(3'b111);
    checks++;
    if (score !== 16'hFFFF || score !== 16'(m_score)) begin
      errors++;
      $display("FAIL sat_triple got score=%h want ffff", score);
    end
    m_y[1] = 40; m_vld[1] = 1;
    force_model();
    h0 = hit_seen;
    press(3'b010);
    checks++;
    if (score !== 16'hFFFF || hit_seen - h0 != 1 || arrow_vld[1] !== 1'b0) begin
      errors++;
      $display("FAIL sat_hold got score=%h pulses=%0d vld1=%b want ffff 1 0", score, hit_seen - h0, arrow_vld[1]);
    end
  endtask

  task automatic test_run_freeze();
    for (int i = 0; i < N; i++) begin m_y[i] = 200 + 100 * i; m_vld[i] = 1; end
    force_model();
    repeat (5) frame_pulse(1'b0);
    checks++;
    if (arrow_y !== {10'd400, 10'd300, 10'd200} || arrow_vld !== 3'b111) begin
      errors++;
      $display("FAIL freeze got y=%h vld=%b want lanes 200/300/400 all active", arrow_y, arrow_vld);
    end
    frame_pulse(1'b1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (arrow_y[i*CW +: CW] !== CW'(m_y[i]) || arrow_vld[i] !== m_vld[i]) begin
        errors++;
        $display("FAIL resume lane%0d got y=%0d vld=%b want y=%0d vld=%b",
                 i, arrow_y[i*CW +: CW], arrow_vld[i], m_y[i], m_vld[i]);
      end
    end
  endtask

  task automatic test_reset_mid_update();
    m_y[0] = 100; m_vld[0] = 1; m_y[1] = PARK; m_vld[1] = 0; m_y[2] = 2; m_vld[2] = 1;
    force_model();
    run = 1'b1; frame = 1'b1;
    @(posedge clk); #1 frame = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    checks++;
    if (arrow_y !== {N{10'd1000}} || arrow_vld !== '0 || score !== 16'd0 || hit !== 1'b0 || miss !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset y=%h vld=%b score=%0d hit=%b miss=%b want reset values", arrow_y, arrow_vld, score, hit, miss);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (miss_seen != exp_misses || arrow_vld !== '0) begin
      errors++;
      $display("FAIL mid_reset_miss got misses=%0d vld=%b want %0d 000", miss_seen, arrow_vld, exp_misses);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 7) begin
        frame_pulse($urandom_range(0, 9) != 0);
      end else begin
        m = N'($urandom_range(0, 7));
        for (int i = 0; i < N; i++)
          if (m_vld[i] && m_y[i] >= 26 && m_y[i] <= 54 && $urandom_range(0, 1) == 1) m[i] = 1'b1;
        press(m);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (arrow_y[i*CW +: CW] !== CW'(m_y[i]) || arrow_vld[i] !== m_vld[i]) begin
          errors++;
          $display("FAIL random op%0d lane%0d got y=%0d vld=%b want y=%0d vld=%b",
                   k, i, arrow_y[i*CW +: CW], arrow_vld[i], m_y[i], m_vld[i]);
        end
      end
      checks++;
      if (score !== 16'(m_score) || hit_seen != exp_hits || miss_seen != exp_misses) begin
        errors++;
        $display("FAIL random op%0d got score=%0d hits=%0d misses=%0d want %0d %0d %0d",
                 k, score, hit_seen, miss_seen, m_score, exp_hits, exp_misses);
      end
    end
  endtask

  initial begin
    exp_hits = 0; exp_misses = 0;
    model_reset();
    test_reset();
    test_spawn();
    test_descend_hit();
    test_window();
    test_miss();
    test_back_to_back();
    test_saturate();
    test_run_freeze();
    test_reset_mid_update();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
